// File: rtl/mpi_recv_responder.sv
// Purpose: MPI rendezvous receiver; accepts SYNC_ENV, replies CLR2SND, forwards DATA payload, replies DONE.
// Latency: CLR2SND valid CTS_DELAY+1 cycles after envelope last; payload passes through with zero latency.
// Backpressure: stream_out held stable until stream_out_ready; payload stream_in_ready follows data_out_ready.
// Build option: define MPI_LEN_CHECK_EN to count payload bytes and report RECV_ERROR on a size mismatch.
module mpi_recv_responder #(
   parameter logic [15:0] MY_RANK   = 16'd0,
   parameter int unsigned CTS_DELAY = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] stream_in_data,
   input  logic [7:0]  stream_in_keep,
   input  logic        stream_in_last,
   input  logic        stream_in_valid,
   output logic        stream_in_ready,
   output logic [63:0] stream_out_data,
   output logic [7:0]  stream_out_keep,
   output logic        stream_out_last,
   output logic        stream_out_valid,
   input  logic        stream_out_ready,
   output logic [63:0] data_out_data,
   output logic [7:0]  data_out_keep,
   output logic        data_out_last,
   output logic        data_out_valid,
   input  logic        data_out_ready,
   output logic [7:0]  peer_rank,
   output logic        busy,
   output logic [15:0] drop_count
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_DRAIN_ENV = 3'd1;
   localparam logic [2:0] S_CTS_WAIT  = 3'd2;
   localparam logic [2:0] S_SEND_CTS  = 3'd3;
   localparam logic [2:0] S_WAIT_DATA = 3'd4;
   localparam logic [2:0] S_PAYLOAD   = 3'd5;
   localparam logic [2:0] S_SEND_DONE = 3'd6;
   localparam logic [2:0] S_DISCARD   = 3'd7;

   // Packet types used by this responder (ASYNC_ENV=3 is never accepted, so it is simply dropped).
   localparam logic [7:0] T_SYNC_ENV = 8'd0;
   localparam logic [7:0] T_CLR2SND  = 8'd1;
   localparam logic [7:0] T_DATA     = 8'd2;
   localparam logic [7:0] T_DONE     = 8'd5;

   localparam logic [7:0] CTS_DLY = CTS_DELAY[7:0];

   logic [2:0]  state;
   logic [2:0]  disc_ret;
   logic [7:0]  tag_q;
   logic [15:0] size_q;
   logic [7:0]  dly_cnt;
   logic [7:0]  done_type;
   logic [15:0] done_size;

   // Header field views of the current inbound word
   logic [7:0]  hdr_tag;
   logic [15:0] hdr_size;
   logic [7:0]  hdr_type;
   logic [7:0]  hdr_src;
   logic [15:0] hdr_dst;
   logic        in_acc;

   assign hdr_tag  = stream_in_data[55:48];
   assign hdr_size = stream_in_data[47:32];
   assign hdr_type = stream_in_data[31:24];
   assign hdr_src  = stream_in_data[23:16];
   assign hdr_dst  = stream_in_data[15:0];
   assign in_acc   = stream_in_valid && stream_in_ready;
   assign busy     = (state != S_IDLE);

   // Inbound ready per state and zero-latency payload pass-through
   always_comb begin
      stream_in_ready = 1'b0;
      data_out_data   = 64'd0;
      data_out_keep   = 8'd0;
      data_out_last   = 1'b0;
      data_out_valid  = 1'b0;
      case (state)
         S_IDLE, S_DRAIN_ENV, S_WAIT_DATA, S_DISCARD: stream_in_ready = 1'b1;
         S_PAYLOAD: begin
            stream_in_ready = data_out_ready;
            data_out_data   = stream_in_data;
            data_out_keep   = stream_in_keep;
            data_out_last   = stream_in_last;
            data_out_valid  = stream_in_valid;
         end
         default: stream_in_ready = 1'b0;
      endcase
   end

`ifdef MPI_LEN_CHECK_EN
   localparam logic [7:0] T_RECV_ERROR = 8'd4;

   logic [15:0] byte_cnt;
   logic [15:0] exp_size;
   logic [3:0]  beat_bytes;
   logic [15:0] byte_total;
   logic [15:0] fin_cnt;
   logic [15:0] fin_exp;

   // Byte count of the current inbound beat
   always_comb begin
      beat_bytes = 4'd0;
      for (int i = 0; i < 8; i++) beat_bytes = beat_bytes + {3'd0, stream_in_keep[i]};
   end

   assign byte_total = byte_cnt + {12'd0, beat_bytes};

   // Completion type: a header-only DATA packet carries zero payload bytes
   always_comb begin
      if (state == S_WAIT_DATA) begin
         fin_cnt = 16'd0;
         fin_exp = hdr_size;
      end else begin
         fin_cnt = byte_total;
         fin_exp = exp_size;
      end
      done_type = (fin_cnt != fin_exp) ? T_RECV_ERROR : T_DONE;
      done_size = (fin_cnt != fin_exp) ? fin_cnt : 16'd0;
   end
`else
   assign done_type = T_DONE;
   assign done_size = 16'd0;
`endif

   // Main control FSM with registered outbound header beat
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= S_IDLE;
         disc_ret         <= S_IDLE;
         tag_q            <= 8'd0;
         size_q           <= 16'd0;
         dly_cnt          <= 8'd0;
         peer_rank        <= 8'd0;
         drop_count       <= 16'd0;
         stream_out_data  <= 64'd0;
         stream_out_keep  <= 8'd0;
         stream_out_last  <= 1'b0;
         stream_out_valid <= 1'b0;
`ifdef MPI_LEN_CHECK_EN
         byte_cnt         <= 16'd0;
         exp_size         <= 16'd0;
`endif
      end else begin
         case (state)
            S_IDLE: if (in_acc) begin
               if (hdr_type == T_SYNC_ENV && hdr_dst == MY_RANK) begin
                  peer_rank <= hdr_src;
                  tag_q     <= hdr_tag;
                  size_q    <= hdr_size;
                  dly_cnt   <= 8'd0;
                  state     <= stream_in_last ? S_CTS_WAIT : S_DRAIN_ENV;
               end else begin
                  if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                  disc_ret <= S_IDLE;
                  state    <= stream_in_last ? S_IDLE : S_DISCARD;
               end
            end
            S_DRAIN_ENV: if (in_acc && stream_in_last) begin
               dly_cnt <= 8'd0;
               state   <= S_CTS_WAIT;
            end
            S_CTS_WAIT: begin
               if (dly_cnt == CTS_DLY) begin
                  stream_out_data  <= {8'd1, tag_q, size_q, T_CLR2SND, MY_RANK[7:0], 8'd0, peer_rank};
                  stream_out_keep  <= 8'hFF;
                  stream_out_last  <= 1'b1;
                  stream_out_valid <= 1'b1;
                  state            <= S_SEND_CTS;
               end else begin
                  dly_cnt <= dly_cnt + 8'd1;
               end
            end
            S_SEND_CTS: if (stream_out_ready) begin
               stream_out_valid <= 1'b0;
               state            <= S_WAIT_DATA;
            end
            S_WAIT_DATA: if (in_acc) begin
               if (hdr_type == T_DATA && hdr_src == peer_rank && hdr_dst == MY_RANK) begin
`ifdef MPI_LEN_CHECK_EN
                  byte_cnt <= 16'd0;
                  exp_size <= hdr_size;
`endif
                  if (stream_in_last) begin
                     stream_out_data  <= {8'd1, tag_q, done_size, done_type, MY_RANK[7:0], 8'd0, peer_rank};
                     stream_out_keep  <= 8'hFF;
                     stream_out_last  <= 1'b1;
                     stream_out_valid <= 1'b1;
                     state            <= S_SEND_DONE;
                  end else begin
                     state <= S_PAYLOAD;
                  end
               end else begin
                  if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                  disc_ret <= S_WAIT_DATA;
                  state    <= stream_in_last ? S_WAIT_DATA : S_DISCARD;
               end
            end
            S_PAYLOAD: if (in_acc) begin
`ifdef MPI_LEN_CHECK_EN
               byte_cnt <= byte_total;
`endif
               if (stream_in_last) begin
                  stream_out_data  <= {8'd1, tag_q, done_size, done_type, MY_RANK[7:0], 8'd0, peer_rank};
                  stream_out_keep  <= 8'hFF;
                  stream_out_last  <= 1'b1;
                  stream_out_valid <= 1'b1;
                  state            <= S_SEND_DONE;
               end
            end
            S_SEND_DONE: if (stream_out_ready) begin
               stream_out_valid <= 1'b0;
               state            <= S_IDLE;
            end
            S_DISCARD: if (in_acc && stream_in_last) state <= disc_ret;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
